// File: rtl/lumos_pkg.sv
// rtl/lumos_pkg.sv - shared state encoding and constants for the LUMOS operand-fetch stage
package lumos_pkg;

    // Operand-fetch FSM states; encoding is shared with debug/trace tooling
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // Architectural zero register; the register file does not hardwire it
    localparam int unsigned X0_INDEX = 0;

endpackage

// File: rtl/operand_select.sv
// rtl/operand_select.sv - per-port operand priority: unused, x0, writeback bypass, register file
import lumos_pkg::*;

module operand_select #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             use_rs,
    input  logic [DEPTH-1:0] index,
    input  logic [WIDTH-1:0] rf_data,
    input  logic             wb_enable,
    input  logic [DEPTH-1:0] wb_index,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] operand
);

    localparam logic [DEPTH-1:0] X0 = DEPTH'(X0_INDEX);

    // Unused and x0 win over the bypass so a writeback to x0 never leaks through
    always_comb begin
        operand = rf_data;
        if (!use_rs) begin
            operand = '0;
        end else if (index == X0) begin
            operand = '0;
        end else if (wb_enable && (wb_index == index)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand-fetch stage: accept request, read register file once, hold operands
import lumos_pkg::*;

module operand_fetch #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [DEPTH-1:0] rs1_index,
    input  logic [DEPTH-1:0] rs2_index,
    output logic             rf_read_enable_1,
    output logic             rf_read_enable_2,
    output logic [DEPTH-1:0] rf_read_index_1,
    output logic [DEPTH-1:0] rf_read_index_2,
    input  logic [WIDTH-1:0] rf_read_data_1,
    input  logic [WIDTH-1:0] rf_read_data_2,
    input  logic             wb_enable,
    input  logic [DEPTH-1:0] wb_index,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] operand_1,
    output logic [WIDTH-1:0] operand_2
);

    fetch_state_t     state;
    fetch_state_t     state_next;

    logic             cap_use_rs1;
    logic             cap_use_rs2;
    logic [DEPTH-1:0] cap_rs1_index;
    logic [DEPTH-1:0] cap_rs2_index;

    logic [WIDTH-1:0] sel_operand_1;
    logic [WIDTH-1:0] sel_operand_2;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one READ cycle per request, HOLD until execute takes the operands
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = READ;
            READ:                   state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Outputs decoded from state and captured fields only, never from in_valid/out_ready
    always_comb begin
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        rf_read_enable_1 = 1'b0;
        rf_read_enable_2 = 1'b0;
        rf_read_index_1  = '0;
        rf_read_index_2  = '0;
        case (state)
            IDLE: in_ready = 1'b1;
            READ: begin
                rf_read_enable_1 = cap_use_rs1;
                rf_read_enable_2 = cap_use_rs2;
                rf_read_index_1  = cap_rs1_index;
                rf_read_index_2  = cap_rs2_index;
            end
            HOLD: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture the decoded request on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_use_rs1   <= 1'b0;
            cap_use_rs2   <= 1'b0;
            cap_rs1_index <= '0;
            cap_rs2_index <= '0;
        end else if (state == IDLE && in_valid) begin
            cap_use_rs1   <= use_rs1;
            cap_use_rs2   <= use_rs2;
            cap_rs1_index <= rs1_index;
            cap_rs2_index <= rs2_index;
        end
    end

    operand_select #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_select_1 (
        .use_rs    (cap_use_rs1),
        .index     (cap_rs1_index),
        .rf_data   (rf_read_data_1),
        .wb_enable (wb_enable),
        .wb_index  (wb_index),
        .wb_data   (wb_data),
        .operand   (sel_operand_1)
    );

    operand_select #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_select_2 (
        .use_rs    (cap_use_rs2),
        .index     (cap_rs2_index),
        .rf_data   (rf_read_data_2),
        .wb_enable (wb_enable),
        .wb_index  (wb_index),
        .wb_data   (wb_data),
        .operand   (sel_operand_2)
    );

    // Operands latch only at the end of READ, so HOLD-time writebacks cannot disturb them
    always_ff @(posedge clk) begin
        if (reset) begin
            operand_1 <= '0;
            operand_2 <= '0;
        end else if (state == READ) begin
            operand_1 <= sel_operand_1;
            operand_2 <= sel_operand_2;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        use_rs1;
    logic        use_rs2;
    logic [4:0]  rs1_index;
    logic [4:0]  rs2_index;
    logic        rf_read_enable_1;
    logic        rf_read_enable_2;
    logic [4:0]  rf_read_index_1;
    logic [4:0]  rf_read_index_2;
    logic [31:0] rf_read_data_1;
    logic [31:0] rf_read_data_2;
    logic        wb_enable;
    logic [4:0]  wb_index;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand_1;
    logic [31:0] operand_2;

    logic [31:0] rf [32];

    int checks = 0;
    int errors = 0;

    operand_fetch #(.WIDTH(32), .DEPTH(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .use_rs1          (use_rs1),
        .use_rs2          (use_rs2),
        .rs1_index        (rs1_index),
        .rs2_index        (rs2_index),
        .rf_read_enable_1 (rf_read_enable_1),
        .rf_read_enable_2 (rf_read_enable_2),
        .rf_read_index_1  (rf_read_index_1),
        .rf_read_index_2  (rf_read_index_2),
        .rf_read_data_1   (rf_read_data_1),
        .rf_read_data_2   (rf_read_data_2),
        .wb_enable        (wb_enable),
        .wb_index         (wb_index),
        .wb_data          (wb_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .operand_1        (operand_1),
        .operand_2        (operand_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_read_data_1 = rf[rf_read_index_1];
    assign rf_read_data_2 = rf[rf_read_index_2];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one edge; the bench register file takes the writeback at that edge
    task automatic tick();
        @(posedge clk);
        if (wb_enable) rf[wb_index] = wb_data;
        #1;
    endtask

    // Present a request for one accepting cycle, then withdraw it
    task automatic issue(input logic u1, input logic u2, input logic [4:0] i1, input logic [4:0] i2);
        in_valid  = 1'b1;
        use_rs1   = u1;
        use_rs2   = u2;
        rs1_index = i1;
        rs2_index = i2;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[5] = 32'h1234;
        rf[6] = 32'hABCD;
        rf[0] = 32'hDEAD;
        rf[7] = 32'h7777;
        rf[8] = 32'h11;
        rf[3] = 32'h99;
        reset = 1'b1; in_valid = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        rs1_index = '0; rs2_index = '0; wb_enable = 1'b0; wb_index = '0;
        wb_data = '0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_op1", operand_1, 0);
        check("rst_op2", operand_2, 0);
        check("rst_en1", rf_read_enable_1, 0);
        check("rst_idx1", rf_read_index_1, 0);

        // Basic: x5/x6
        issue(1, 1, 5'd5, 5'd6);
        check("basic_read_in_ready", in_ready, 0);
        check("basic_read_out_valid", out_valid, 0);
        check("basic_read_en1", rf_read_enable_1, 1);
        check("basic_read_en2", rf_read_enable_2, 1);
        check("basic_read_idx1", rf_read_index_1, 5);
        check("basic_read_idx2", rf_read_index_2, 6);
        tick();
        check("basic_hold_out_valid", out_valid, 1);
        check("basic_op1", operand_1, 32'h1234);
        check("basic_op2", operand_2, 32'hABCD);
        check("basic_hold_in_ready", in_ready, 0);
        check("basic_hold_en1", rf_read_enable_1, 0);
        check("basic_hold_idx2", rf_read_index_2, 0);
        tick();
        check("basic_idle_in_ready", in_ready, 1);
        check("basic_idle_out_valid", out_valid, 0);

        // x0 forcing despite x0 holding 0xDEAD in the register file
        issue(1, 1, 5'd0, 5'd0);
        check("x0_read_en1", rf_read_enable_1, 1);
        check("x0_read_en2", rf_read_enable_2, 1);
        tick();
        check("x0_op1", operand_1, 0);
        check("x0_op2", operand_2, 0);
        check("x0_hold_en1", rf_read_enable_1, 0);
        check("x0_hold_en2", rf_read_enable_2, 0);
        tick();

        // Bypass from a writeback landing in the READ cycle
        issue(1, 1, 5'd7, 5'd8);
        wb_enable = 1'b1; wb_index = 5'd7; wb_data = 32'h55AA;
        tick();
        wb_enable = 1'b0;
        check("byp_op1", operand_1, 32'h55AA);
        check("byp_op2", operand_2, 32'h11);
        tick();

        // Writeback to x0 must not bypass
        issue(1, 1, 5'd0, 5'd8);
        wb_enable = 1'b1; wb_index = 5'd0; wb_data = 32'h55AA;
        tick();
        wb_enable = 1'b0;
        check("byp_x0_op1", operand_1, 0);
        check("byp_x0_op2", operand_2, 32'h11);
        tick();

        // Same index on both ports with bypass
        issue(1, 1, 5'd9, 5'd9);
        wb_enable = 1'b1; wb_index = 5'd9; wb_data = 32'hCAFE0009;
        tick();
        wb_enable = 1'b0;
        check("same_op1", operand_1, 32'hCAFE0009);
        check("same_op2", operand_2, 32'hCAFE0009);
        tick();

        // Backpressure with writebacks to rs1 during HOLD
        out_ready = 1'b0;
        issue(1, 1, 5'd5, 5'd6);
        tick();
        wb_enable = 1'b1; wb_index = 5'd5; wb_data = 32'hFFFF0000;
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_op1", operand_1, 32'h1234);
            check("bp_op2", operand_2, 32'hABCD);
            wb_data = wb_data + 1;
            tick();
        end
        wb_enable = 1'b0;
        check("bp_still_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);

        // Unused rs2
        issue(1, 0, 5'd6, 5'd3);
        check("unused_en1", rf_read_enable_1, 1);
        check("unused_en2", rf_read_enable_2, 0);
        tick();
        check("unused_op1", operand_1, 32'hABCD);
        check("unused_op2", operand_2, 0);
        tick();

        // Reset in READ
        issue(1, 1, 5'd8, 5'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_read_out_valid", out_valid, 0);
        check("rst_read_op1", operand_1, 0);
        check("rst_read_op2", operand_2, 0);
        check("rst_read_in_ready", in_ready, 1);
        tick();
        check("rst_read_stays_idle", out_valid, 0);

        // Reset in HOLD
        out_ready = 1'b0;
        issue(1, 1, 5'd8, 5'd3);
        tick();
        check("pre_rst_hold_op1", operand_1, 32'h11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        check("rst_hold_out_valid", out_valid, 0);
        check("rst_hold_op1", operand_1, 0);
        check("rst_hold_op2", operand_2, 0);
        check("rst_hold_in_ready", in_ready, 1);

        // Normal request after reset
        issue(1, 1, 5'd3, 5'd8);
        tick();
        check("post_rst_out_valid", out_valid, 1);
        check("post_rst_op1", operand_1, 32'h99);
        check("post_rst_op2", operand_2, 32'h11);
        tick();
        check("post_rst_in_ready", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
